// File: rtl/encrypt_pipe_shift_rot_if.sv
// ============================================================================
// Module   : encrypt_pipe_shift_rot_if
// Brief    : Config, symbol-in and FIFO-out bundle for the shift/rotate stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface encrypt_pipe_shift_rot_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               key_load;
    logic [4:0]         key_in;
    logic               decrypt_in;
    logic               en_in;
    logic               is_alpha_upper_case_in;
    logic               is_alpha_low_case_in;
    logic [25:0]        extended_shift_data_in;
    logic               sticky_clr;
    logic               dout_ready;
    logic               dout_valid;
    logic [7:0]         dout;
    logic [c_CNT_W-1:0] fifo_count;
    logic               overflow;
    logic               code_err;

    modport master (
        output key_load, key_in, decrypt_in, en_in,
               is_alpha_upper_case_in, is_alpha_low_case_in,
               extended_shift_data_in, sticky_clr, dout_ready,
        input  dout_valid, dout, fifo_count, overflow, code_err
    );

    modport slave (
        input  key_load, key_in, decrypt_in, en_in,
               is_alpha_upper_case_in, is_alpha_low_case_in,
               extended_shift_data_in, sticky_clr, dout_ready,
        output dout_valid, dout, fifo_count, overflow, code_err
    );
endinterface

`default_nettype wire

// File: rtl/encrypt_pipe_shift_rot.sv
// ============================================================================
// Module   : encrypt_pipe_shift_rot
// Brief    : Caesar rotate of a one-hot letter, ASCII re-encode, output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encrypt_pipe_shift_rot #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    encrypt_pipe_shift_rot_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Key configuration
    // ------------------------------------------------------------------
    logic [4:0] r_key;
    logic       r_decrypt;
    logic [4:0] w_rot_amt;
    logic [5:0] w_base;
    logic [51:0] w_dbl;
    logic [25:0] w_rotated;
    logic        w_alpha_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key     <= 5'd0;
            r_decrypt <= 1'b0;
        end else if (bus.key_load) begin
            r_key     <= (bus.key_in > 5'd25) ? (bus.key_in - 5'd26) : bus.key_in;
            r_decrypt <= bus.decrypt_in;
        end
    end

    always_comb begin
        w_rot_amt = r_key;
        if (r_decrypt && (r_key != 5'd0)) begin
            w_rot_amt = 5'd26 - r_key;
        end
    end

    // rot[j] = data[(j - r) mod 26]: a 26-bit window into the doubled vector
    assign w_dbl      = {bus.extended_shift_data_in, bus.extended_shift_data_in};
    assign w_base     = 6'd26 - {1'b0, w_rot_amt};
    assign w_rotated  = w_dbl[w_base +: 26];
    assign w_alpha_in = bus.is_alpha_upper_case_in | bus.is_alpha_low_case_in;

    // ------------------------------------------------------------------
    // Stage A: rotate
    // ------------------------------------------------------------------
    logic        r_valid_a;
    logic [25:0] r_rot;
    logic        r_upper_a;
    logic        r_lower_a;
    logic [7:0]  r_data8_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_a <= 1'b0;
            r_rot     <= 26'd0;
            r_upper_a <= 1'b0;
            r_lower_a <= 1'b0;
            r_data8_a <= 8'd0;
        end else begin
            r_valid_a <= bus.en_in;
            if (bus.en_in) begin
                r_rot     <= w_alpha_in ? w_rotated : bus.extended_shift_data_in;
                r_upper_a <= bus.is_alpha_upper_case_in;
                r_lower_a <= bus.is_alpha_low_case_in;
                r_data8_a <= bus.extended_shift_data_in[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: one-hot to ASCII
    // ------------------------------------------------------------------
    logic       w_alpha_a;
    logic       w_onehot;
    logic [4:0] w_idx;
    logic [7:0] w_byte;
    logic       w_code_err_set;
    logic       r_valid_b;
    logic [7:0] r_byte_b;
    logic       r_code_err;

    assign w_alpha_a = r_upper_a | r_lower_a;
    assign w_onehot  = (r_rot != 26'd0) && ((r_rot & (r_rot - 26'd1)) == 26'd0);

    always_comb begin
        w_idx = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (r_rot[i]) begin
                w_idx = 5'(i);
            end
        end
    end

    always_comb begin
        w_byte = r_data8_a;
        if (w_alpha_a) begin
            if (!w_onehot) begin
                w_byte = 8'h3F;
            end else begin
                w_byte = (r_upper_a ? 8'd65 : 8'd97) + {3'b000, w_idx};
            end
        end
    end

    assign w_code_err_set = r_valid_a & w_alpha_a & ~w_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_b <= 1'b0;
            r_byte_b  <= 8'd0;
        end else begin
            r_valid_b <= r_valid_a;
            if (r_valid_a) begin
                r_byte_b <= w_byte;
            end
        end
    end

    // A set event in the same cycle as sticky_clr wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code_err <= 1'b0;
        end else if (w_code_err_set) begin
            r_code_err <= 1'b1;
        end else if (bus.sticky_clr) begin
            r_code_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_write;
    logic               w_drop;

    assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & bus.dout_ready;
    // A full FIFO still accepts a push when the head is leaving this cycle
    assign w_write = r_valid_b & (~w_full | w_pop);
    assign w_drop  = r_valid_b & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else if (w_write) begin
            r_mem[r_wr_ptr] <= r_byte_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.sticky_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.dout_valid = ~w_empty;
    assign bus.dout       = r_mem[r_rd_ptr];
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.code_err   = r_code_err;

endmodule

`default_nettype wire
